bldc_commutation_ctrl: RTL and testbench

BLDC_COMMUTATION_CTRL -- requirements
Module: bldc_commutation_ctrl

---
 rtl/bldc_commutation_ctrl_if.sv | 25 ++
 rtl/bldc_commutation_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_bldc_commutation_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/bldc_commutation_ctrl_if.sv
// Command/status bundle for the BLDC commutation controller.
// master: the supervisor that issues run requests and reads gate/state status.
// slave : the commutation controller itself.
interface bldc_commutation_ctrl_if;
    logic       enable;
    logic       dir;
    logic [7:0] duty;
    logic [2:0] hall;
    logic       fault_clr;
    logic [2:0] hin;
    logic [2:0] lin_n;
    logic [2:0] step;
    logic [2:0] mode;
    logic       fault;

    modport master (
        output enable, dir, duty, hall, fault_clr,
        input  hin, lin_n, step, mode, fault
    );

    modport slave (
        input  enable, dir, duty, hall, fault_clr,
        output hin, lin_n, step, mode, fault
    );
endinterface

// File: rtl/bldc_commutation_ctrl.sv
// Six-step BLDC commutation: align, open-loop ramp, hall lock, closed-loop
// commutation with stall/invalid-hall fault, PWM on the low side and dead time
// after every step change.

// One bridge phase: high side is static, low side is chopped by the PWM.
module bldc_phase_drv (
    input  logic drive_hi,
    input  logic drive_lo,
    input  logic pwm_on,
    output logic hin,
    output logic lin_n
);
    assign hin   = drive_hi;
    assign lin_n = ~(drive_lo & pwm_on);
endmodule

module bldc_commutation_ctrl #(
    parameter int STEP_CYCLES  = 2700,
    parameter int ALIGN_CYCLES = 8100,
    parameter int DEAD_CYCLES  = 4,
    parameter int LOCK_EDGES   = 12,
    parameter int STALL_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bldc_commutation_ctrl_if.slave   bus
);
    // One shared timer serves align, open-loop step and stall timing.
    localparam int TMAX = (STALL_CYCLES > ALIGN_CYCLES)
                        ? ((STALL_CYCLES > STEP_CYCLES) ? STALL_CYCLES : STEP_CYCLES)
                        : ((ALIGN_CYCLES > STEP_CYCLES) ? ALIGN_CYCLES : STEP_CYCLES);
    localparam int TW = $clog2(TMAX + 1);
    localparam int LW = $clog2(LOCK_EDGES + 1);
    localparam int DW = $clog2(DEAD_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        OPEN   = 3'd2,
        CLOSED = 3'd3,
        FAULT  = 3'd4
    } mode_e;

    mode_e           mode_q, mode_n;
    logic [2:0]      step_q, step_n;
    logic [TW-1:0]   timer_q, timer_n;
    logic [LW-1:0]   lock_q, lock_n;
    logic [DW-1:0]   dead_q, dead_n;
    logic            dir_q, dir_n;
    logic [7:0]      pwm_q;
    logic [1:0][2:0] hall_sync_q;
    logic [2:0]      hall_prev_q;
    logic            inval_q;

    logic [2:0]      hall_s;
    logic [2:0]      hall_step;
    logic            hall_ok;
    logic            hall_edge;
    logic            edge_ok;
    logic [2:0]      step_fwd;
    logic            lock_hit;
    logic            pwm_on;
    logic            gate_en;
    logic [2:0]      hi_sel, lo_sel;
    logic [2:0]      hin_w, lin_n_w;

    // +1 forward / -1 reverse, modulo 6.
    function automatic logic [2:0] step_adv(input logic [2:0] s, input logic rev);
        if (rev) return (s == 3'd0) ? 3'd5 : s - 3'd1;
        return (s == 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    assign hall_s    = hall_sync_q[1];
    assign hall_edge = (hall_s != hall_prev_q);
    assign edge_ok   = hall_edge && hall_ok;
    assign step_fwd  = step_adv(step_q, dir_q);
    assign pwm_on    = (pwm_q < bus.duty);

    // Hall code to rotor sector; 000 and 111 flag a sensor fault.
    always_comb begin
        hall_ok   = 1'b1;
        hall_step = 3'd0;
        case (hall_s)
            3'b001:  hall_step = 3'd0;
            3'b011:  hall_step = 3'd1;
            3'b010:  hall_step = 3'd2;
            3'b110:  hall_step = 3'd3;
            3'b100:  hall_step = 3'd4;
            3'b101:  hall_step = 3'd5;
            default: hall_ok   = 1'b0;
        endcase
    end

    // Sequencer next state: mode, step, timers, lock count, direction latch.
    always_comb begin
        mode_n   = mode_q;
        step_n   = step_q;
        timer_n  = timer_q;
        lock_n   = lock_q;
        dir_n    = dir_q;
        lock_hit = 1'b0;
        case (mode_q)
            IDLE: begin
                step_n  = 3'd0;
                timer_n = '0;
                lock_n  = '0;
                if (bus.enable) begin
                    mode_n = ALIGN;
                    dir_n  = bus.dir;
                end
            end
            ALIGN: begin
                if (!bus.enable) begin
                    mode_n  = IDLE;
                    timer_n = '0;
                end else if (timer_q == TW'(ALIGN_CYCLES - 1)) begin
                    mode_n  = OPEN;
                    timer_n = '0;
                end else begin
                    timer_n = timer_q + TW'(1);
                end
            end
            OPEN: begin
                if (!bus.enable) begin
                    mode_n  = IDLE;
                    timer_n = '0;
                end else begin
                    // Lock tracks hall edges against the open-loop next step.
                    if (edge_ok && hall_step == step_fwd) begin
                        if (lock_q == LW'(LOCK_EDGES - 1)) lock_hit = 1'b1;
                        else                               lock_n   = lock_q + LW'(1);
                    end else if (hall_edge) begin
                        lock_n = '0;
                    end
                    // Lock takes priority; a coincident timer step is dropped.
                    if (lock_hit) begin
                        mode_n  = CLOSED;
                        timer_n = '0;
                        lock_n  = '0;
                    end else if (timer_q == TW'(STEP_CYCLES - 1)) begin
                        step_n  = step_fwd;
                        timer_n = '0;
                    end else begin
                        timer_n = timer_q + TW'(1);
                    end
                end
            end
            CLOSED: begin
                if (!bus.enable) begin
                    mode_n  = IDLE;
                    timer_n = '0;
                end else if (!hall_ok && inval_q) begin
                    mode_n  = FAULT;
                    timer_n = '0;
                end else if (edge_ok) begin
                    step_n  = step_adv(hall_step, dir_q);
                    timer_n = '0;
                end else if (timer_q == TW'(STALL_CYCLES - 1)) begin
                    mode_n  = FAULT;
                    timer_n = '0;
                end else begin
                    timer_n = timer_q + TW'(1);
                end
            end
            FAULT: begin
                timer_n = '0;
                if (bus.fault_clr && !bus.enable) mode_n = IDLE;
            end
            default: begin
                mode_n  = IDLE;
                timer_n = '0;
            end
        endcase

        // Any step change restarts the dead-time window.
        dead_n = dead_q;
        if (step_n != step_q)    dead_n = DW'(DEAD_CYCLES);
        else if (dead_q != '0)   dead_n = dead_q - DW'(1);
    end

    // State registers, hall synchronizer and free-running PWM counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= IDLE;
            step_q      <= 3'd0;
            timer_q     <= '0;
            lock_q      <= '0;
            dead_q      <= '0;
            dir_q       <= 1'b0;
            pwm_q       <= 8'd0;
            hall_sync_q <= '0;
            hall_prev_q <= 3'd0;
            inval_q     <= 1'b0;
        end else begin
            mode_q      <= mode_n;
            step_q      <= step_n;
            timer_q     <= timer_n;
            lock_q      <= lock_n;
            dead_q      <= dead_n;
            dir_q       <= dir_n;
            pwm_q       <= pwm_q + 8'd1;
            hall_sync_q <= {hall_sync_q[0], bus.hall};
            hall_prev_q <= hall_s;
            inval_q     <= ~hall_ok;
        end
    end

    // Step table: which phase is sourced (high) and which is sunk (low).
    always_comb begin
        hi_sel = 3'b000;
        lo_sel = 3'b000;
        case (step_q)
            3'd0: begin hi_sel = 3'b100; lo_sel = 3'b010; end
            3'd1: begin hi_sel = 3'b100; lo_sel = 3'b001; end
            3'd2: begin hi_sel = 3'b010; lo_sel = 3'b001; end
            3'd3: begin hi_sel = 3'b010; lo_sel = 3'b100; end
            3'd4: begin hi_sel = 3'b001; lo_sel = 3'b100; end
            3'd5: begin hi_sel = 3'b001; lo_sel = 3'b010; end
            default: begin hi_sel = 3'b000; lo_sel = 3'b000; end
        endcase
    end

    // enable is used raw so dropping it kills the gates in the same cycle.
    assign gate_en = bus.enable && (dead_q == '0) &&
                     (mode_q == ALIGN || mode_q == OPEN || mode_q == CLOSED);

    generate
        for (genvar g = 0; g < 3; g++) begin : g_phase
            bldc_phase_drv u_drv (
                .drive_hi (gate_en & hi_sel[g]),
                .drive_lo (gate_en & lo_sel[g]),
                .pwm_on   (pwm_on),
                .hin      (hin_w[g]),
                .lin_n    (lin_n_w[g])
            );
        end
    endgenerate

    assign bus.hin   = hin_w;
    assign bus.lin_n = lin_n_w;
    assign bus.step  = step_q;
    assign bus.mode  = mode_q;
    assign bus.fault = (mode_q == FAULT);
endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Directed bench for bldc_commutation_ctrl. Timing parameters are scaled down
// so that align, lock, stall and restart all fit in a short run; dead time and
// lock count keep their defaults.
module tb_bldc_commutation_ctrl;
    localparam int ALIGN_C = 200;
    localparam int STEP_C  = 100;
    localparam int DEAD_C  = 4;
    localparam int LOCK_C  = 12;
    localparam int STALL_C = 1000;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b1;
    int     n_pass  = 0;
    int     n_fail  = 0;
    int     n_total = 0;
    int     n, m;
    longint t0;

    bldc_commutation_ctrl_if bus();

    bldc_commutation_ctrl #(
        .STEP_CYCLES  (STEP_C),
        .ALIGN_CYCLES (ALIGN_C),
        .DEAD_CYCLES  (DEAD_C),
        .LOCK_EDGES   (LOCK_C),
        .STALL_CYCLES (STALL_C)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    function automatic logic [2:0] hcode(input int s);
        case (s % 6)
            0:       return 3'b001;
            1:       return 3'b011;
            2:       return 3'b010;
            3:       return 3'b110;
            4:       return 3'b100;
            default: return 3'b101;
        endcase
    endfunction

    // Drive one in-sequence hall edge per open-loop window until lock.
    task automatic do_lock(input int start);
        int s, w;
        for (int k = 0; k < LOCK_C; k++) begin
            s = (start + k) % 6;
            chk("ol_step", bus.step, s);
            if (k == LOCK_C - 1) chk("pre_lock_mode", bus.mode, 2);
            bus.hall = hcode(s + 1);
            if (k < LOCK_C - 1) begin
                w = 0;
                while (bus.step == s[2:0] && w < STEP_C + 20) begin w++; cyc(1); end
            end
        end
        cyc(5);
        chk("lock_mode", bus.mode, 3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        bus.enable = 1'b1; bus.dir = 1'b0; bus.duty = 8'd128;
        bus.hall = 3'b001; bus.fault_clr = 1'b0;

        // Reset with enable high: everything off at once.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mode",  bus.mode,  0);
        chk("rst_hin",   bus.hin,   3'b000);
        chk("rst_lin",   bus.lin_n, 3'b111);
        chk("rst_fault", bus.fault, 0);
        chk("rst_step",  bus.step,  0);
        cyc(3);
        bus.enable = 1'b0; rst_n = 1'b1;
        cyc(5);
        chk("post_rst_mode", bus.mode, 0);
        chk("post_rst_hin",  bus.hin,  3'b000);

        // Startup: align on step 0, then open-loop stepping with dead gaps.
        bus.enable = 1'b1;
        cyc(1);
        chk("align_mode", bus.mode, 1);
        chk("align_hin",  bus.hin,  3'b100);
        chk("align_lin",  bus.lin_n | 3'b010, 3'b111);
        n = 0;
        while (bus.mode == 3'd1 && n < ALIGN_C + 20) begin n++; cyc(1); end
        chk("align_len",  n, ALIGN_C);
        chk("open_mode",  bus.mode, 2);
        chk("open_step0", bus.step, 0);
        n = 0;
        while (bus.step == 3'd0 && n < STEP_C + 20) begin n++; cyc(1); end
        chk("step_len",   n, STEP_C);
        chk("open_step1", bus.step, 1);
        n = 0;
        while (bus.hin == 3'b000 && bus.lin_n == 3'b111 && n < 20) begin n++; cyc(1); end
        chk("dead_len",  n, DEAD_C);
        chk("step1_hin", bus.hin, 3'b100);

        // Lock, then closed-loop commutation from hall.
        do_lock(1);
        chk("lock_step", bus.step, 0);
        cyc(150);
        chk("closed_hold_mode", bus.mode, 3);
        chk("closed_hold_step", bus.step, 0);
        bus.hall = 3'b010;
        cyc(10);
        chk("closed_step3", bus.step, 3);
        chk("closed_hin3",  bus.hin,  3'b010);
        bus.hall = 3'b011;
        t0 = $time;
        cyc(3);
        chk("closed_step2", bus.step, 2);
        chk("closed_dead",  bus.hin,  3'b000);
        cyc(4);
        chk("closed_hin2",  bus.hin,  3'b010);

        // PWM: step 2 sinks on T.
        bus.duty = 8'd64;
        n = 0; m = 0;
        repeat (256) begin
            cyc(1);
            if (!bus.lin_n[0]) n++;
            if (bus.lin_n[2:1] != 2'b11) m++;
        end
        chk("pwm64",      n, 64);
        chk("pwm64_idle", m, 0);
        bus.duty = 8'd0;
        n = 0;
        repeat (256) begin
            cyc(1);
            if (bus.lin_n != 3'b111) n++;
        end
        chk("pwm0", n, 0);

        // Stall: hall frozen since t0.
        n = 0;
        while (bus.mode != 3'd4 && n < STALL_C + 100) begin n++; cyc(1); end
        chk("stall_cycles", 32'(($time - t0) / 10), STALL_C + 3);
        chk("stall_fault",  bus.fault, 1);
        chk("stall_hin",    bus.hin,   3'b000);
        chk("stall_lin",    bus.lin_n, 3'b111);
        bus.fault_clr = 1'b1; cyc(1); bus.fault_clr = 1'b0; cyc(1);
        chk("clr_ignored", bus.mode, 4);
        bus.enable = 1'b0;
        cyc(2);
        chk("fault_hold", bus.mode, 4);
        bus.fault_clr = 1'b1; cyc(1); bus.fault_clr = 1'b0;
        chk("clr_idle",  bus.mode,  0);
        chk("clr_fault", bus.fault, 0);

        // Second run: lock from step 0, then invalid-hall handling.
        bus.hall = 3'b001; bus.duty = 8'd128; bus.enable = 1'b1;
        cyc(1);
        n = 0;
        while (bus.mode == 3'd1 && n < ALIGN_C + 20) begin n++; cyc(1); end
        chk("run2_open", bus.mode, 2);
        do_lock(0);
        chk("run2_lock_step", bus.step, 5);
        bus.hall = 3'b111; cyc(1); bus.hall = 3'b001;
        cyc(10);
        chk("glitch_no_fault", bus.mode, 3);
        chk("glitch_step",     bus.step, 1);
        bus.hall = 3'b111; cyc(2); bus.hall = 3'b001;
        cyc(4);
        chk("inval_fault", bus.mode,  4);
        chk("inval_flag",  bus.fault, 1);
        bus.enable = 1'b0; bus.fault_clr = 1'b1; cyc(1); bus.fault_clr = 1'b0;
        chk("inval_clr", bus.mode, 0);

        // Enable drop kills gates combinationally.
        bus.dir = 1'b1; bus.enable = 1'b1;
        cyc(10);
        chk("run3_hin", bus.hin, 3'b100);
        bus.enable = 1'b0;
        #1;
        chk("kill_hin", bus.hin,   3'b000);
        chk("kill_lin", bus.lin_n, 3'b111);
        cyc(1);
        chk("kill_idle", bus.mode, 0);

        // Reset mid-align, then reverse direction latched in IDLE.
        bus.enable = 1'b1;
        cyc(10);
        chk("realign_hin", bus.hin, 3'b100);
        rst_n = 1'b0;
        #1;
        chk("rst2_hin",  bus.hin,   3'b000);
        chk("rst2_lin",  bus.lin_n, 3'b111);
        chk("rst2_mode", bus.mode,  0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("rev_align", bus.mode, 1);
        bus.dir = 1'b0;
        n = 0;
        while (bus.mode == 3'd1 && n < ALIGN_C + 20) begin n++; cyc(1); end
        n = 0;
        while (bus.step == 3'd0 && n < STEP_C + 20) begin n++; cyc(1); end
        chk("rev_step", bus.step, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
